// File: rtl/mlp_pkg.sv
// mlp_pkg: shared definitions for the mlp neuron datapath.
//   - default fixed-point widths (Q with MLP_FRAC_BITS fractional bits)
//   - neuron_state_e: neuron processing-element FSM states
//   - relu_sat(): rescaled accumulator -> ReLU with saturation to OUT_WIDTH
package mlp_pkg;

  localparam int MLP_IN_WIDTH  = 16;
  localparam int MLP_WGT_WIDTH = 16;
  localparam int MLP_MAC_WIDTH = 32;
  localparam int MLP_OUT_WIDTH = 16;
  localparam int MLP_FRAC_BITS = MLP_WGT_WIDTH / 2;
  localparam int MLP_MAX_TERMS = 8;

  // Largest positive value representable in the signed result, at MAC width.
  localparam logic signed [MLP_MAC_WIDTH-1:0] MLP_OUT_MAX =
    {{(MLP_MAC_WIDTH-MLP_OUT_WIDTH+1){1'b0}}, {(MLP_OUT_WIDTH-1){1'b1}}};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    FINAL = 2'd2,
    OUT   = 2'd3
  } neuron_state_e;

  typedef struct packed {
    logic [MLP_OUT_WIDTH-1:0] value;
    logic                     sat;
  } relu_sat_t;

  // Negative inputs clip to 0 (not a saturation); values above the signed
  // result range clamp to the positive maximum and raise sat.
  function automatic relu_sat_t relu_sat(input logic signed [MLP_MAC_WIDTH-1:0] s);
    relu_sat_t r;
    r.value = '0;
    r.sat   = 1'b0;
    if (s < 0) begin
      r.value = '0;
    end else if (s > MLP_OUT_MAX) begin
      r.value = {1'b0, {(MLP_OUT_WIDTH-1){1'b1}}};
      r.sat   = 1'b1;
    end else begin
      r.value = s[MLP_OUT_WIDTH-1:0];
    end
    return r;
  endfunction

endpackage

// File: rtl/mlp_mult_sext.sv
// mlp_mult_sext: combinational full-precision signed multiply, result
// sign-extended to the accumulator width.
//   a : signed A_WIDTH operand
//   b : signed B_WIDTH operand
//   p : signed MAC_WIDTH product (wraps if MAC_WIDTH < A_WIDTH+B_WIDTH)
module mlp_mult_sext #(
  parameter int A_WIDTH   = 16,
  parameter int B_WIDTH   = 16,
  parameter int MAC_WIDTH = 32
) (
  input  logic signed [A_WIDTH-1:0]   a,
  input  logic signed [B_WIDTH-1:0]   b,
  output logic signed [MAC_WIDTH-1:0] p
);

  logic signed [A_WIDTH+B_WIDTH-1:0] prod;

  assign prod = a * b;
  assign p    = MAC_WIDTH'(prod);

endmodule

// File: rtl/mlp_neuron_mac.sv
// mlp_neuron_mac: sequential fixed-point neuron. Loads a bias, accumulates a
// stream of (x, w) products, rescales by FRAC_BITS and applies ReLU with
// saturation (RELU_EN=1) or plain truncation (RELU_EN=0).
//   clk, rst            : clock, asynchronous active-high reset
//   start, n_terms, bias: begin an evaluation (sampled in IDLE only)
//   in_valid/in_ready   : (x_in, w_in) pair handshake
//   out_valid/out_ready : result handshake; result and sat held until taken
//   busy                : FSM not in IDLE
module mlp_neuron_mac
  import mlp_pkg::*;
#(
  parameter int IN_WIDTH  = MLP_IN_WIDTH,
  parameter int WGT_WIDTH = MLP_WGT_WIDTH,
  parameter int MAC_WIDTH = MLP_MAC_WIDTH,
  parameter int OUT_WIDTH = MLP_OUT_WIDTH,
  parameter int FRAC_BITS = MLP_FRAC_BITS,
  parameter int MAX_TERMS = MLP_MAX_TERMS,
  parameter bit RELU_EN   = 1'b1
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               start,
  input  logic [$clog2(MAX_TERMS+1)-1:0]     n_terms,
  input  logic [WGT_WIDTH-1:0]               bias,
  input  logic                               in_valid,
  output logic                               in_ready,
  input  logic [IN_WIDTH-1:0]                x_in,
  input  logic [WGT_WIDTH-1:0]               w_in,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic [OUT_WIDTH-1:0]               result,
  output logic                               sat,
  output logic                               busy
);

  localparam int CNT_WIDTH = $clog2(MAX_TERMS+1);

  neuron_state_e                state_reg;
  logic signed [MAC_WIDTH-1:0]  acc_reg;
  logic [CNT_WIDTH-1:0]         cnt_reg;
  logic [OUT_WIDTH-1:0]         result_reg;
  logic                         sat_reg;
  logic                         out_valid_reg;

  logic signed [MAC_WIDTH-1:0]  product;
  logic signed [MAC_WIDTH-1:0]  bias_acc;
  logic signed [MAC_WIDTH-1:0]  shifted;
  logic [CNT_WIDTH-1:0]         n_terms_clamped;
  logic [OUT_WIDTH-1:0]         final_value;
  logic                         final_sat;

  mlp_mult_sext #(
    .A_WIDTH   (IN_WIDTH),
    .B_WIDTH   (WGT_WIDTH),
    .MAC_WIDTH (MAC_WIDTH)
  ) u_mult (
    .a (x_in),
    .b (w_in),
    .p (product)
  );

  // Bias is in the same Q format as x and w, so it is aligned to the
  // product's 2*FRAC_BITS fractional bits before seeding the accumulator.
  assign bias_acc = {{(MAC_WIDTH-WGT_WIDTH){bias[WGT_WIDTH-1]}}, bias} <<< FRAC_BITS;
  assign shifted  = acc_reg >>> FRAC_BITS;

  assign n_terms_clamped = (n_terms > CNT_WIDTH'(MAX_TERMS)) ? CNT_WIDTH'(MAX_TERMS) : n_terms;

  generate
    if (RELU_EN) begin : g_relu
      relu_sat_t rs;
      assign rs          = relu_sat(shifted);
      assign final_value = rs.value;
      assign final_sat   = rs.sat;
    end else begin : g_trunc
      assign final_value = shifted[OUT_WIDTH-1:0];
      assign final_sat   = 1'b0;
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= IDLE;
      acc_reg       <= '0;
      cnt_reg       <= '0;
      result_reg    <= '0;
      sat_reg       <= 1'b0;
      out_valid_reg <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (start) begin
            acc_reg   <= bias_acc;
            cnt_reg   <= n_terms_clamped;
            state_reg <= (n_terms_clamped != '0) ? ACCUM : FINAL;
          end
        end
        ACCUM: begin
          if (in_valid) begin
            acc_reg <= acc_reg + product;
            cnt_reg <= cnt_reg - 1'b1;
            if (cnt_reg == CNT_WIDTH'(1)) state_reg <= FINAL;
          end
        end
        FINAL: begin
          result_reg    <= final_value;
          sat_reg       <= final_sat;
          out_valid_reg <= 1'b1;
          state_reg     <= OUT;
        end
        OUT: begin
          if (out_ready) begin
            out_valid_reg <= 1'b0;
            state_reg     <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  // in_ready is decoded straight from the state register so a pair can be
  // taken on every cycle of ACCUM, including the first.
  assign in_ready  = (state_reg == ACCUM);
  assign busy      = (state_reg != IDLE);
  assign out_valid = out_valid_reg;
  assign result    = result_reg;
  assign sat       = sat_reg;

endmodule

// File: tb/tb_mlp_neuron_mac.sv
// Bench for mlp_neuron_mac: a ReLU instance and a truncating instance share
// one stimulus stream; expected results are queued at start and popped when
// out_valid appears.
module tb_mlp_neuron_mac;

  localparam int CW = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [CW-1:0] n_terms;
  logic [15:0] bias;
  logic        in_valid;
  logic [15:0] x_in;
  logic [15:0] w_in;
  logic        out_ready;

  logic        r_in_ready, r_out_valid, r_sat, r_busy;
  logic [15:0] r_result;
  logic        t_in_ready, t_out_valid, t_sat, t_busy;
  logic [15:0] t_result;

  always #5 clk = ~clk;

  mlp_neuron_mac #(.RELU_EN(1'b1)) u_relu (
    .clk(clk), .rst(rst), .start(start), .n_terms(n_terms), .bias(bias),
    .in_valid(in_valid), .in_ready(r_in_ready), .x_in(x_in), .w_in(w_in),
    .out_valid(r_out_valid), .out_ready(out_ready), .result(r_result),
    .sat(r_sat), .busy(r_busy)
  );

  mlp_neuron_mac #(.RELU_EN(1'b0)) u_trunc (
    .clk(clk), .rst(rst), .start(start), .n_terms(n_terms), .bias(bias),
    .in_valid(in_valid), .in_ready(t_in_ready), .x_in(x_in), .w_in(w_in),
    .out_valid(t_out_valid), .out_ready(out_ready), .result(t_result),
    .sat(t_sat), .busy(t_busy)
  );

  typedef struct {
    logic [15:0] res;
    logic        sat;
  } exp_t;

  exp_t q_relu[$];
  exp_t q_trunc[$];

  int err_cnt = 0;
  int chk_cnt = 0;

  logic signed [15:0] px[8];
  logic signed [15:0] pw[8];
  logic [15:0] last_relu, last_trunc;
  logic        last_sat;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: Q8.8 bias/inputs/weights, 32-bit wrapping accumulator.
  task automatic push_model(input logic [15:0] b, input int n);
    longint             acc;
    logic signed [31:0] w32;
    logic signed [31:0] s32;
    exp_t               er, et;
    acc = longint'($signed(b)) * 256;
    for (int k = 0; k < n; k++) acc += longint'(px[k]) * longint'(pw[k]);
    w32 = acc[31:0];
    s32 = w32 >>> 8;
    if (s32 < 0) begin
      er.res = 16'h0000; er.sat = 1'b0;
    end else if (s32 > 32767) begin
      er.res = 16'h7FFF; er.sat = 1'b1;
    end else begin
      er.res = s32[15:0]; er.sat = 1'b0;
    end
    et.res = s32[15:0];
    et.sat = 1'b0;
    q_relu.push_back(er);
    q_trunc.push_back(et);
  endtask

  task automatic run(input string name, input logic [15:0] b, input int n_req,
                     input int n_pairs, input bit gaps, input int hold,
                     input bit start_with_valid);
    int   k, cyc;
    bit   tog, acc_now;
    exp_t er, et;
    @(negedge clk);
    start    = 1'b1;
    n_terms  = CW'(n_req);
    bias     = b;
    in_valid = start_with_valid;
    x_in     = px[0];
    w_in     = pw[0];
    push_model(b, n_pairs);
    @(negedge clk);
    start    = 1'b0;
    in_valid = 1'b0;
    if (n_pairs == 0) check_val({name, "_no_rdy0"}, {31'd0, r_in_ready}, 32'd0);
    k = 0; cyc = 0; tog = 1'b1;
    while (k < n_pairs && cyc < 100) begin
      in_valid = gaps ? tog : 1'b1;
      tog      = !tog;
      x_in     = px[k];
      w_in     = pw[k];
      acc_now  = in_valid && r_in_ready;
      @(negedge clk);
      cyc++;
      if (acc_now) k++;
    end
    if (k < n_pairs) check_val({name, "_accept_timeout"}, k, n_pairs);
    in_valid = 1'b0;
    check_val({name, "_lat_early"}, {30'd0, r_out_valid, t_out_valid}, 32'd0);
    if (n_pairs == 0) check_val({name, "_no_rdy1"}, {31'd0, r_in_ready}, 32'd0);
    @(negedge clk);
    check_val({name, "_lat"}, {30'd0, r_out_valid, t_out_valid}, 32'd3);
    if (q_relu.size() == 0 || q_trunc.size() == 0) begin
      check_val({name, "_sb_empty"}, 0, 1);
      return;
    end
    er = q_relu.pop_front();
    et = q_trunc.pop_front();
    check_val({name, "_relu_res"}, r_result, er.res);
    check_val({name, "_relu_sat"}, r_sat, er.sat);
    check_val({name, "_trunc_res"}, t_result, et.res);
    check_val({name, "_trunc_sat"}, t_sat, et.sat);
    last_relu  = r_result;
    last_trunc = t_result;
    last_sat   = r_sat;
    $display("run %s: n=%0d bias=0x%h relu=0x%h sat=%b trunc=0x%h",
             name, n_pairs, b, r_result, r_sat, t_result);
    for (int h = 0; h < hold; h++) begin
      out_ready = 1'b0;
      start     = 1'b1;
      @(negedge clk);
      start     = 1'b0;
      check_val({name, "_hold_vb"}, {28'd0, r_out_valid, r_busy, t_out_valid, t_busy}, 32'hF);
      check_val({name, "_hold_res"}, {r_result, t_result}, {er.res, et.res});
      check_val({name, "_hold_sat"}, {30'd0, r_sat, t_sat}, {30'd0, er.sat, et.sat});
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check_val({name, "_idle"}, {28'd0, r_out_valid, r_busy, t_out_valid, t_busy}, 32'd0);
  endtask

  task automatic load_s1();
    px[0] = 16'sh FF00; pw[0] = 16'sh 0100;
    px[1] = 16'sh 0200; pw[1] = 16'sh 0080;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst = 1'b1; start = 1'b0; n_terms = '0; bias = '0; in_valid = 1'b0;
    x_in = '0; w_in = '0; out_ready = 1'b0;
    for (int k = 0; k < 8; k++) begin px[k] = '0; pw[k] = '0; end
    @(negedge clk);
    @(negedge clk);
    check_val("reset_outs", {27'd0, r_in_ready, r_out_valid, r_sat, r_busy, 1'b0}, 32'd0);
    check_val("reset_res", {r_result, t_result}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check_val("post_reset", {28'd0, r_in_ready, r_out_valid, r_busy, t_busy}, 32'd0);

    load_s1();
    run("s1", 16'h0080, 2, 2, 1'b0, 0, 1'b1);
    check_val("s1_const", last_relu, 16'h0080);
    check_val("s1_const_sat", last_sat, 1'b0);

    run("s1_gaps", 16'h0080, 2, 2, 1'b1, 0, 1'b0);
    check_val("s1_gaps_const", last_relu, 16'h0080);

    px[0] = 16'sh FF00; pw[0] = 16'sh 0200;
    px[1] = 16'sh 0200; pw[1] = 16'sh 0000;
    run("neg", 16'h0000, 2, 2, 1'b0, 0, 1'b0);
    check_val("neg_relu_const", last_relu, 16'h0000);
    check_val("neg_trunc_const", last_trunc, 16'hFE00);

    px[0] = 16'sh 0200; pw[0] = 16'sh 7F00;
    run("sat", 16'h7F00, 1, 1, 1'b0, 0, 1'b0);
    check_val("sat_const", last_relu, 16'h7FFF);
    check_val("sat_const_flag", last_sat, 1'b1);

    run("n0", 16'h0300, 0, 0, 1'b0, 5, 1'b0);
    check_val("n0_const", last_relu, 16'h0300);

    for (int k = 0; k < 8; k++) begin
      px[k] = 16'($urandom_range(0, 1023)) - 16'sd512;
      pw[k] = 16'($urandom_range(0, 1023)) - 16'sd512;
    end
    run("clamp", 16'h0100, 12, 8, 1'b0, 1, 1'b0);

    for (int r = 0; r < 8; r++) begin
      n = $urandom_range(0, 8);
      for (int k = 0; k < 8; k++) begin
        px[k] = 16'($urandom);
        pw[k] = 16'($urandom);
      end
      run($sformatf("rnd%0d", r), 16'($urandom), n, n, 1'($urandom_range(0, 1)),
          $urandom_range(0, 2), 1'($urandom_range(0, 1)));
    end

    // Abort mid-accumulation: one of two pairs taken, then reset.
    load_s1();
    @(negedge clk);
    start = 1'b1; n_terms = CW'(2); bias = 16'h0080;
    @(negedge clk);
    start = 1'b0; in_valid = 1'b1; x_in = px[0]; w_in = pw[0];
    check_val("abort_ready", {30'd0, r_in_ready, r_busy}, 32'd3);
    @(negedge clk);
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    check_val("abort_outs", {28'd0, r_in_ready, r_out_valid, r_sat, r_busy}, 32'd0);
    check_val("abort_res", {r_result, t_result}, 32'd0);
    $display("run abort: reset asserted after 1 of 2 pairs");
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check_val("abort_no_ov", {30'd0, r_out_valid, t_out_valid}, 32'd0);
    end
    run("s1_after_rst", 16'h0080, 2, 2, 1'b0, 0, 1'b0);
    check_val("s1_after_rst_const", last_relu, 16'h0080);

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
